// File: rtl/mouse_config_ctrl.sv
// Runtime configuration sequencer for the PS/2 mouse link: borrows the shared
// transmitter/receiver from the master SM and runs F5 / opcode / [arg] / F4 with ACK checking.
module mouse_config_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 2000000,
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned CTR_WIDTH   = 21
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CMD_REQ,
  input  logic [1:0] CMD_CODE,
  input  logic [7:0] CMD_ARG,
  output logic       CMD_BUSY,
  output logic       CMD_DONE,
  output logic       CMD_ERR,
  output logic [1:0] CMD_ERR_CODE,
  output logic       HOLD,
  input  logic       HOLD_ACK,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY
);

  localparam int unsigned RETRY_W = 8;
  localparam logic [1:0]  ERR_TMO = 2'b01;
  localparam logic [1:0]  ERR_NAK = 2'b10;
  localparam logic [1:0]  ERR_CMD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD_WAIT, S_SEND, S_SEND_WAIT, S_WAIT_ACK, S_DONE, S_ERR
  } state_t;

  state_t               r_state, w_state_next;
  logic [1:0]           r_code, r_idx, w_idx_next, r_err_code, w_err_code_next;
  logic [7:0]           r_arg, r_byte;
  logic [RETRY_W-1:0]   r_retry, w_retry_next;
  logic [CTR_WIDTH-1:0] r_ctr;
  logic                 r_hold, r_busy, r_done, r_err, r_send, r_rden;
  logic                 w_accept, w_tmo, w_ctr_clr, w_link;

  function automatic logic f_valid(input logic [1:0] code, input logic [7:0] arg);
    case (code)
      2'b00:   f_valid = arg inside {8'd10, 8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd200};
      2'b01:   f_valid = (arg <= 8'd3);
      2'b10:   f_valid = 1'b1;
      default: f_valid = 1'b0;
    endcase
  endfunction

  // Byte index 0..3 = disable reporting, opcode, argument, enable reporting
  function automatic logic [7:0] f_byte(input logic [1:0] idx, input logic [1:0] code,
                                        input logic [7:0] arg);
    case (idx)
      2'd0:    f_byte = 8'hF5;
      2'd1:    f_byte = (code == 2'b00) ? 8'hF3 :
                        (code == 2'b01) ? 8'hE8 : {7'b1110011, arg[0]};
      2'd2:    f_byte = arg;
      default: f_byte = 8'hF4;
    endcase
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx;
    w_retry_next    = r_retry;
    w_err_code_next = r_err_code;
    w_accept        = 1'b0;
    w_tmo           = (r_ctr >= CTR_WIDTH'(ACK_TIMEOUT - 1));
    case (r_state)
      S_IDLE: begin
        if (CMD_REQ) begin
          if (f_valid(CMD_CODE, CMD_ARG)) begin
            w_accept        = 1'b1;
            w_err_code_next = 2'b00;
            w_idx_next      = 2'd0;
            w_retry_next    = '0;
            w_state_next    = S_HOLD_WAIT;
          end else begin
            w_err_code_next = ERR_CMD;
            w_state_next    = S_ERR;
          end
        end
      end
      S_HOLD_WAIT: begin
        if (HOLD_ACK) w_state_next = S_SEND;
        else if (w_tmo) begin
          w_err_code_next = ERR_TMO;
          w_state_next    = S_ERR;
        end
      end
      S_SEND: w_state_next = S_SEND_WAIT;
      S_SEND_WAIT: begin
        if (BYTE_SENT) w_state_next = S_WAIT_ACK;
        else if (w_tmo) begin
          w_err_code_next = ERR_TMO;
          w_state_next    = S_ERR;
        end
      end
      S_WAIT_ACK: begin
        // A received byte beats a coinciding timeout; stale stream bytes fall through
        if (BYTE_READY) begin
          if ((BYTE_ERROR_CODE != 2'b00) || (BYTE_READ == 8'hFE)) begin
            if (r_retry < RETRY_W'(MAX_RETRY)) begin
              w_retry_next = r_retry + RETRY_W'(1);
              w_state_next = S_SEND;
            end else begin
              w_err_code_next = ERR_NAK;
              w_state_next    = S_ERR;
            end
          end else if (BYTE_READ == 8'hFA) begin
            w_retry_next = '0;
            if (r_idx == 2'd3) begin
              w_state_next = S_DONE;
            end else begin
              w_idx_next   = ((r_idx == 2'd1) && (r_code == 2'b10)) ? 2'd3 : r_idx + 2'd1;
              w_state_next = S_SEND;
            end
          end else if (BYTE_READ == 8'hFC) begin
            w_err_code_next = ERR_NAK;
            w_state_next    = S_ERR;
          end
        end else if (w_tmo) begin
          w_err_code_next = ERR_TMO;
          w_state_next    = S_ERR;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_link    = (w_state_next == S_HOLD_WAIT) || (w_state_next == S_SEND) ||
                     (w_state_next == S_SEND_WAIT) || (w_state_next == S_WAIT_ACK);
  assign w_ctr_clr = (w_state_next != r_state) &&
                     ((w_state_next == S_HOLD_WAIT) || (w_state_next == S_SEND) ||
                      (w_state_next == S_WAIT_ACK));

  // Datapath and outputs, registered from the next-state decode
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_code     <= '0;
      r_arg      <= '0;
      r_idx      <= '0;
      r_retry    <= '0;
      r_ctr      <= '0;
      r_err_code <= '0;
      r_byte     <= '0;
      r_hold     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_send     <= 1'b0;
      r_rden     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_code <= CMD_CODE;
        r_arg  <= CMD_ARG;
      end
      r_idx      <= w_idx_next;
      r_retry    <= w_retry_next;
      r_err_code <= w_err_code_next;
      r_ctr      <= w_ctr_clr ? '0 : r_ctr + CTR_WIDTH'(1);
      if (w_state_next == S_SEND) r_byte <= f_byte(w_idx_next, r_code, r_arg);
      r_hold     <= w_link;
      r_busy     <= w_link;
      r_done     <= (w_state_next == S_DONE);
      r_err      <= (w_state_next == S_ERR);
      r_send     <= (w_state_next == S_SEND);
      r_rden     <= (w_state_next == S_WAIT_ACK);
    end
  end

  assign CMD_BUSY     = r_busy;
  assign CMD_DONE     = r_done;
  assign CMD_ERR      = r_err;
  assign CMD_ERR_CODE = r_err_code;
  assign HOLD         = r_hold;
  assign SEND_BYTE    = r_send;
  assign BYTE_TO_SEND = r_byte;
  assign READ_ENABLE  = r_rden;

endmodule

// File: tb/tb_mouse_config_ctrl.sv
// Directed bench for mouse_config_ctrl with a scripted mouse responder.
module tb_mouse_config_ctrl;

  localparam int unsigned TMO = 1000;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       CMD_REQ;
  logic [1:0] CMD_CODE;
  logic [7:0] CMD_ARG;
  logic       CMD_BUSY, CMD_DONE, CMD_ERR;
  logic [1:0] CMD_ERR_CODE;
  logic       HOLD, HOLD_ACK;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         hold_cnt = 0;
  logic [7:0] sent_q [$];
  logic [7:0] nak_byte;
  logic [7:0] mute_byte;
  logic       stale_en;

  mouse_config_ctrl #(.ACK_TIMEOUT(TMO), .MAX_RETRY(2), .CTR_WIDTH(21)) dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_REQ(CMD_REQ), .CMD_CODE(CMD_CODE), .CMD_ARG(CMD_ARG),
    .CMD_BUSY(CMD_BUSY), .CMD_DONE(CMD_DONE), .CMD_ERR(CMD_ERR), .CMD_ERR_CODE(CMD_ERR_CODE),
    .HOLD(HOLD), .HOLD_ACK(HOLD_ACK),
    .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
    .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ), .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .BYTE_READY(BYTE_READY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [1:0] c, input logic [7:0] a);
    CMD_CODE = c;
    CMD_ARG  = a;
    CMD_REQ  = 1'b1;
    tick();
    CMD_REQ  = 1'b0;
  endtask

  task automatic grant(input string tag);
    int n = 0;
    while (!HOLD && n < 50) begin tick(); n++; end
    chk({tag, "_hold"}, 32'(HOLD), 32'd1);
    repeat (5) tick();
    HOLD_ACK = 1'b1;
  endtask

  task automatic wait_end(input string tag, output logic d, output logic e);
    int n = 0;
    while (!(CMD_DONE || CMD_ERR) && n < 5000) begin tick(); n++; end
    chk({tag, "_term"}, 32'(n < 5000), 32'd1);
    d = CMD_DONE;
    e = CMD_ERR;
    chk({tag, "_excl"}, 32'(CMD_DONE & CMD_ERR), 32'd0);
    chk({tag, "_hold_end"}, 32'(HOLD), 32'd0);
    chk({tag, "_busy_end"}, 32'(CMD_BUSY), 32'd0);
    HOLD_ACK = 1'b0;
  endtask

  task automatic chk_bytes(input string tag, input int base, input logic [7:0] exp_q [$]);
    chk({tag, "_nbytes"}, 32'(sent_q.size() - base), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (base + i < sent_q.size())
        chk($sformatf("%s_b%0d", tag, i), 32'(sent_q[base + i]), 32'(exp_q[i]));
  endtask

  // Mouse model: log each sent byte, report transmit done, then ACK/NAK/stay silent
  initial begin
    logic [7:0] b;
    BYTE_SENT = 1'b0; BYTE_READY = 1'b0; BYTE_READ = 8'h00; BYTE_ERROR_CODE = 2'b00;
    forever begin
      @(posedge CLK); #1;
      BYTE_READY = 1'b0;
      if (SEND_BYTE) begin
        b = BYTE_TO_SEND;
        sent_q.push_back(b);
        repeat (3) begin @(posedge CLK); #1; end
        BYTE_SENT = 1'b1;
        @(posedge CLK); #1;
        BYTE_SENT = 1'b0;
        if (b == mute_byte) begin
          if (stale_en) begin
            for (int k = 0; k < 3; k++) begin
              @(posedge CLK); #1;
              BYTE_READ  = (k == 0) ? 8'h08 : 8'(k);
              BYTE_READY = 1'b1;
              @(posedge CLK); #1;
              BYTE_READY = 1'b0;
            end
          end
        end else begin
          @(posedge CLK); #1;
          BYTE_READ  = (b == nak_byte) ? 8'hFE : 8'hFA;
          BYTE_READY = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK); #1;
      if (CMD_DONE) done_cnt++;
      if (HOLD) hold_cnt++;
    end
  end

  initial begin
    logic       d, e;
    logic [7:0] exp_q [$];
    int         base, dbase, hbase, n, cyc;
    RESET = 1'b1; CMD_REQ = 1'b0; CMD_CODE = 2'b00; CMD_ARG = 8'h00; HOLD_ACK = 1'b0;
    nak_byte = 8'h00; mute_byte = 8'h00; stale_en = 1'b0;
    repeat (3) tick();
    chk("rst_hold", 32'(HOLD), 32'd0);
    chk("rst_busy", 32'(CMD_BUSY), 32'd0);
    chk("rst_byte", 32'(BYTE_TO_SEND), 32'd0);
    chk("rst_errc", 32'(CMD_ERR_CODE), 32'd0);
    chk("rst_rden", 32'(READ_ENABLE), 32'd0);
    RESET = 1'b0;
    repeat (2) tick();

    // Sample rate 100, all ACKs
    base = sent_q.size(); dbase = done_cnt;
    issue(2'b00, 8'd100);
    chk("t1_busy", 32'(CMD_BUSY), 32'd1);
    grant("t1");
    wait_end("t1", d, e);
    chk("t1_done", 32'(d), 32'd1);
    exp_q = '{8'hF5, 8'hF3, 8'h64, 8'hF4};
    chk_bytes("t1", base, exp_q);
    repeat (10) tick();
    chk("t1_ndone", 32'(done_cnt - dbase), 32'd1);

    // Bad resolution argument
    base = sent_q.size(); hbase = hold_cnt;
    issue(2'b01, 8'd5);
    chk("t2_err", 32'(CMD_ERR), 32'd1);
    chk("t2_code", 32'(CMD_ERR_CODE), 32'd3);
    chk("t2_busy", 32'(CMD_BUSY), 32'd0);
    repeat (5) tick();
    chk("t2_pulse", 32'(CMD_ERR), 32'd0);
    chk("t2_code_held", 32'(CMD_ERR_CODE), 32'd3);
    chk("t2_nohold", 32'(hold_cnt - hbase), 32'd0);
    chk("t2_nosend", 32'(sent_q.size() - base), 32'd0);

    // Resolution 2, opcode NAKed until retries run out
    base = sent_q.size(); nak_byte = 8'hE8;
    issue(2'b01, 8'd2);
    chk("t3_code_clr", 32'(CMD_ERR_CODE), 32'd0);
    grant("t3");
    wait_end("t3", d, e);
    chk("t3_err", 32'(e), 32'd1);
    chk("t3_code", 32'(CMD_ERR_CODE), 32'd2);
    exp_q = '{8'hF5, 8'hE8, 8'hE8, 8'hE8};
    chk_bytes("t3", base, exp_q);
    nak_byte = 8'h00;
    repeat (5) tick();

    // Stale bytes after F5, then timeout
    base = sent_q.size(); mute_byte = 8'hF5; stale_en = 1'b1;
    issue(2'b00, 8'd10);
    grant("t4");
    n = 0;
    while (!READ_ENABLE && n < 100) begin tick(); n++; end
    chk("t4_rden", 32'(READ_ENABLE), 32'd1);
    cyc = 0;
    while (!CMD_ERR && cyc < int'(TMO) + 50) begin tick(); cyc++; end
    chk("t4_latency", 32'(cyc), 32'(TMO));
    chk("t4_code", 32'(CMD_ERR_CODE), 32'd1);
    chk("t4_hold", 32'(HOLD), 32'd0);
    exp_q = '{8'hF5};
    chk_bytes("t4", base, exp_q);
    HOLD_ACK = 1'b0; mute_byte = 8'h00; stale_en = 1'b0;
    repeat (5) tick();

    // Scaling 2:1 with a request while busy
    base = sent_q.size(); dbase = done_cnt;
    issue(2'b10, 8'd1);
    grant("t5");
    n = 0;
    while (sent_q.size() == base && n < 100) begin tick(); n++; end
    issue(2'b00, 8'd100);
    wait_end("t5", d, e);
    chk("t5_done", 32'(d), 32'd1);
    exp_q = '{8'hF5, 8'hE7, 8'hF4};
    chk_bytes("t5", base, exp_q);
    repeat (10) tick();
    chk("t5_ndone", 32'(done_cnt - dbase), 32'd1);
    chk("t5_idle_hold", 32'(HOLD), 32'd0);

    // Reset while waiting for the F3 ACK, then a normal command
    base = sent_q.size(); mute_byte = 8'hF3;
    issue(2'b00, 8'd20);
    grant("t6");
    n = 0;
    while (!(READ_ENABLE && sent_q.size() - base == 2) && n < 200) begin tick(); n++; end
    chk("t6_in_ack", 32'(READ_ENABLE), 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("t6_rst_hold", 32'(HOLD), 32'd0);
    chk("t6_rst_busy", 32'(CMD_BUSY), 32'd0);
    chk("t6_rst_rden", 32'(READ_ENABLE), 32'd0);
    tick(); tick();
    RESET = 1'b0; HOLD_ACK = 1'b0; mute_byte = 8'h00;
    tick();
    chk("t6_rst_byte", 32'(BYTE_TO_SEND), 32'd0);
    base = sent_q.size();
    issue(2'b01, 8'd3);
    grant("t6b");
    wait_end("t6b", d, e);
    chk("t6b_done", 32'(d), 32'd1);
    exp_q = '{8'hF5, 8'hE8, 8'h03, 8'hF4};
    chk_bytes("t6b", base, exp_q);

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
